// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: shared encodings for the multi-cycle control unit (ALU bus bits, opcodes, selects, states).
// Revision 1.0
`default_nettype none
package mc_ctrl_fsm_pkg;

  localparam int ALU_W = 14;

  localparam int ALU_HUI  = 13;
  localparam int ALU_NXOR = 12;
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_HUI   = 6'b011111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_NXOR = 6'b101000;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic       SRC1_RS   = 1'b0;
  localparam logic       SRC1_SA   = 1'b1;
  localparam logic [1:0] SRC2_RT   = 2'd0;
  localparam logic [1:0] SRC2_SEXT = 2'd1;
  localparam logic [1:0] SRC2_ZEXT = 2'd2;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_ALU   = 3'd0,
    K_LOAD  = 3'd1,
    K_STORE = 3'd2,
    K_BEQ   = 3'd3,
    K_BNE   = 3'd4,
    K_JUMP  = 3'd5
  } kind_t;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic             src1;
    logic [1:0]       src2;
    kind_t            kind;
    logic [4:0]       waddr;
  } ctrl_t;

  function automatic logic [ALU_W-1:0] alu_bit(input int idx);
    return ALU_W'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_fsm_inst_decode.sv
// mc_ctrl_fsm_inst_decode: combinational instruction word -> control bundle and illegal flag.
// Revision 1.0
`default_nettype none
module mc_ctrl_fsm_inst_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = inst[31:26];
  assign funct         = inst[5:0];
  assign unused_fields = ^{inst[25:21], inst[10:6]};

  always_comb begin
    ctrl       = '0;
    illegal    = 1'b0;
    ctrl.waddr = inst[20:16];
    case (op)
      OP_RTYPE: begin
        ctrl.waddr = inst[15:11];
        case (funct)
          FN_ADDU: ctrl.alu = alu_bit(ALU_ADD);
          FN_SUBU: ctrl.alu = alu_bit(ALU_SUB);
          FN_SLT:  ctrl.alu = alu_bit(ALU_SLT);
          FN_SLTU: ctrl.alu = alu_bit(ALU_SLTU);
          FN_AND:  ctrl.alu = alu_bit(ALU_AND);
          FN_OR:   ctrl.alu = alu_bit(ALU_OR);
          FN_XOR:  ctrl.alu = alu_bit(ALU_XOR);
          FN_NOR:  ctrl.alu = alu_bit(ALU_NOR);
          FN_NXOR: ctrl.alu = alu_bit(ALU_NXOR);
          FN_SLL:  begin ctrl.alu = alu_bit(ALU_SLL); ctrl.src1 = SRC1_SA; end
          FN_SRL:  begin ctrl.alu = alu_bit(ALU_SRL); ctrl.src1 = SRC1_SA; end
          FN_SRA:  begin ctrl.alu = alu_bit(ALU_SRA); ctrl.src1 = SRC1_SA; end
          FN_SLLV: ctrl.alu = alu_bit(ALU_SLL);
          FN_SRLV: ctrl.alu = alu_bit(ALU_SRL);
          FN_SRAV: ctrl.alu = alu_bit(ALU_SRA);
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDIU: begin ctrl.alu = alu_bit(ALU_ADD);  ctrl.src2 = SRC2_SEXT; end
      OP_SLTI:  begin ctrl.alu = alu_bit(ALU_SLT);  ctrl.src2 = SRC2_SEXT; end
      OP_SLTIU: begin ctrl.alu = alu_bit(ALU_SLTU); ctrl.src2 = SRC2_SEXT; end
      OP_ANDI:  begin ctrl.alu = alu_bit(ALU_AND);  ctrl.src2 = SRC2_ZEXT; end
      OP_ORI:   begin ctrl.alu = alu_bit(ALU_OR);   ctrl.src2 = SRC2_ZEXT; end
      OP_XORI:  begin ctrl.alu = alu_bit(ALU_XOR);  ctrl.src2 = SRC2_ZEXT; end
      OP_LUI:   begin ctrl.alu = alu_bit(ALU_LUI);  ctrl.src2 = SRC2_ZEXT; end
      OP_HUI:   begin ctrl.alu = alu_bit(ALU_HUI);  ctrl.src2 = SRC2_ZEXT; end
      OP_LW: begin
        ctrl.alu  = alu_bit(ALU_ADD);
        ctrl.src2 = SRC2_SEXT;
        ctrl.kind = K_LOAD;
      end
      OP_SW: begin
        ctrl.alu  = alu_bit(ALU_ADD);
        ctrl.src2 = SRC2_SEXT;
        ctrl.kind = K_STORE;
      end
      OP_BEQ:  begin ctrl.alu = alu_bit(ALU_SUB); ctrl.kind = K_BEQ; end
      OP_BNE:  begin ctrl.alu = alu_bit(ALU_SUB); ctrl.kind = K_BNE; end
      OP_J:    ctrl.kind = K_JUMP;
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle FETCH/DECODE/EXE/MEM/WB controller driving the one-hot ALU bus and datapath strobes.
// Revision 1.0
`default_nettype none
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic [13:0] alu_control,
  output logic        alu_src1_sel,
  output logic [1:0]  alu_src2_sel,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        mem_err,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic        rf_wsrc,
  output logic        pc_wen,
  output logic [1:0]  pc_sel,
  output logic        inst_done,
  output logic        inst_illegal
);

  localparam int              CNT_W    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      inst_q;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl_dec;
  logic             dec_illegal;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_expire;

  mc_ctrl_fsm_inst_decode u_decode (
    .inst    (inst_q),
    .ctrl    (ctrl_dec),
    .illegal (dec_illegal)
  );

  assign mem_expire = (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // wait_cnt counts completed MEM cycles of the current access only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q   <= '0;
      ctrl_q   <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == ST_FETCH && inst_valid) begin
        inst_q <= inst;
      end
      if (state == ST_DECODE) begin
        ctrl_q <= ctrl_dec;
      end
      if (state == ST_MEM && state_nxt == ST_MEM) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (inst_valid) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = dec_illegal ? ST_FETCH : ST_EXE;
      ST_EXE: begin
        case (ctrl_q.kind)
          K_LOAD, K_STORE: state_nxt = ST_MEM;
          K_ALU:           state_nxt = ST_WB;
          default:         state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_nxt = (ctrl_q.kind == K_LOAD) ? ST_WB : ST_FETCH;
        end else if (mem_expire) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_WB:   state_nxt = ST_FETCH;
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    inst_ready   = 1'b0;
    alu_control  = '0;
    alu_src1_sel = 1'b0;
    alu_src2_sel = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_err      = 1'b0;
    rf_wen       = 1'b0;
    rf_waddr     = 5'd0;
    rf_wsrc      = 1'b0;
    pc_wen       = 1'b0;
    pc_sel       = PC_SEQ;
    inst_done    = 1'b0;
    inst_illegal = 1'b0;
    case (state)
      ST_FETCH: inst_ready = 1'b1;
      ST_DECODE: begin
        inst_illegal = dec_illegal;
        inst_done    = dec_illegal;
      end
      ST_EXE: begin
        alu_control  = ctrl_q.alu;
        alu_src1_sel = ctrl_q.src1;
        alu_src2_sel = ctrl_q.src2;
        pc_wen       = 1'b1;
        case (ctrl_q.kind)
          K_BEQ:   begin pc_sel = alu_zero  ? PC_BRANCH : PC_SEQ; inst_done = 1'b1; end
          K_BNE:   begin pc_sel = !alu_zero ? PC_BRANCH : PC_SEQ; inst_done = 1'b1; end
          K_JUMP:  begin pc_sel = PC_JUMP; inst_done = 1'b1; end
          default: pc_sel = PC_SEQ;
        endcase
      end
      ST_MEM: begin
        alu_control  = ctrl_q.alu;
        alu_src1_sel = ctrl_q.src1;
        alu_src2_sel = ctrl_q.src2;
        mem_req      = 1'b1;
        mem_we       = (ctrl_q.kind == K_STORE);
        // an ack on the expiry cycle completes normally
        if (mem_ack) begin
          inst_done = (ctrl_q.kind == K_STORE);
        end else if (mem_expire) begin
          mem_err   = 1'b1;
          inst_done = 1'b1;
        end
      end
      ST_WB: begin
        rf_wen    = 1'b1;
        rf_waddr  = ctrl_q.waddr;
        rf_wsrc   = (ctrl_q.kind == K_LOAD);
        inst_done = 1'b1;
      end
      default: inst_ready = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed and randomized instruction streams checked cycle by cycle against a table-driven reference.
// Revision 1.0
`default_nettype none
module tb_mc_ctrl_fsm;

  localparam int MEM_WAIT_MAX = 15;
  localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BEQ = 3, C_BNE = 4, C_J = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [13:0] alu_control;
  logic        alu_src1_sel;
  logic [1:0]  alu_src2_sel;
  logic        alu_zero;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        mem_err;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic        rf_wsrc;
  logic        pc_wen;
  logic [1:0]  pc_sel;
  logic        inst_done;
  logic        inst_illegal;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_ready   (inst_ready),
    .alu_control  (alu_control),
    .alu_src1_sel (alu_src1_sel),
    .alu_src2_sel (alu_src2_sel),
    .alu_zero     (alu_zero),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .mem_err      (mem_err),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wsrc      (rf_wsrc),
    .pc_wen       (pc_wen),
    .pc_sel       (pc_sel),
    .inst_done    (inst_done),
    .inst_illegal (inst_illegal)
  );

  typedef struct packed {
    logic        ready;
    logic [13:0] alu;
    logic        s1;
    logic [1:0]  s2;
    logic        mreq;
    logic        mwe;
    logic        merr;
    logic        rfw;
    logic [4:0]  wa;
    logic        ws;
    logic        pcw;
    logic [1:0]  pcs;
    logic        done;
    logic        ill;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         use_fn;
    int         alu;
    bit         s1;
    logic [1:0] s2;
    int         cls;
  } ent_t;

  ent_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add_ent(input logic [5:0] op, input logic [5:0] fn, input bit use_fn,
                         input int alu, input bit s1, input logic [1:0] s2, input int cls);
    ent_t e;
    e.op = op; e.fn = fn; e.use_fn = use_fn; e.alu = alu; e.s1 = s1; e.s2 = s2; e.cls = cls;
    tbl.push_back(e);
  endtask

  task automatic init_table();
    add_ent(6'h00, 6'h21, 1, 11, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h23, 1, 10, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h2a, 1,  9, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h2b, 1,  8, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h24, 1,  7, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h25, 1,  5, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h26, 1,  4, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h27, 1,  6, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h28, 1, 12, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h00, 1,  3, 1, 2'd0, C_ALU);
    add_ent(6'h00, 6'h02, 1,  2, 1, 2'd0, C_ALU);
    add_ent(6'h00, 6'h03, 1,  1, 1, 2'd0, C_ALU);
    add_ent(6'h00, 6'h04, 1,  3, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h06, 1,  2, 0, 2'd0, C_ALU);
    add_ent(6'h00, 6'h07, 1,  1, 0, 2'd0, C_ALU);
    add_ent(6'h09, 6'h00, 0, 11, 0, 2'd1, C_ALU);
    add_ent(6'h0a, 6'h00, 0,  9, 0, 2'd1, C_ALU);
    add_ent(6'h0b, 6'h00, 0,  8, 0, 2'd1, C_ALU);
    add_ent(6'h0c, 6'h00, 0,  7, 0, 2'd2, C_ALU);
    add_ent(6'h0d, 6'h00, 0,  5, 0, 2'd2, C_ALU);
    add_ent(6'h0e, 6'h00, 0,  4, 0, 2'd2, C_ALU);
    add_ent(6'h0f, 6'h00, 0,  0, 0, 2'd2, C_ALU);
    add_ent(6'h1f, 6'h00, 0, 13, 0, 2'd2, C_ALU);
    add_ent(6'h23, 6'h00, 0, 11, 0, 2'd1, C_LD);
    add_ent(6'h2b, 6'h00, 0, 11, 0, 2'd1, C_ST);
    add_ent(6'h04, 6'h00, 0, 10, 0, 2'd0, C_BEQ);
    add_ent(6'h05, 6'h00, 0, 10, 0, 2'd0, C_BNE);
    add_ent(6'h02, 6'h00, 0, -1, 0, 2'd0, C_J);
  endtask

  function automatic int find(input logic [31:0] w);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].op == w[31:26] && (!tbl[i].use_fn || tbl[i].fn == w[5:0])) return i;
    end
    return -1;
  endfunction

  function automatic obs_t idle();
    obs_t o;
    o       = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ready = inst_ready;   o.alu  = alu_control; o.s1  = alu_src1_sel; o.s2   = alu_src2_sel;
    o.mreq  = mem_req;      o.mwe  = mem_we;      o.merr = mem_err;     o.rfw  = rf_wen;
    o.wa    = rf_waddr;     o.ws   = rf_wsrc;     o.pcw = pc_wen;       o.pcs  = pc_sel;
    o.done  = inst_done;    o.ill  = inst_illegal;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic ack, input logic z,
                      input obs_t exp, input string tag);
    inst_valid = v; inst = w; mem_ack = ack; alu_zero = z;
    @(negedge clk);
    chk(tag, sample(), exp);
    @(posedge clk);
    #1;
  endtask

  // ack_at: MEM cycle (1-based) carrying mem_ack, 0 or > MEM_WAIT_MAX = none.
  // rst_at: post-handshake cycle in which rst is raised, 0 = none.
  task automatic run_inst(input logic [31:0] w, input int ack_at, input bit zero, input int rst_at);
    obs_t q[$];
    obs_t d, x, m, wb;
    ent_t e;
    logic [13:0] one;
    int idx, nm, mi;
    bit is_mem, in_mem, ack;
    idx = find(w);
    nm = 0; is_mem = 0;
    d = '0;
    if (idx < 0) begin
      d.ill = 1'b1; d.done = 1'b1;
      q.push_back(d);
    end else begin
      e = tbl[idx];
      q.push_back(d);
      x = '0; one = 14'd1;
      if (e.alu >= 0) x.alu = one << e.alu;
      x.s1 = e.s1; x.s2 = e.s2; x.pcw = 1'b1;
      case (e.cls)
        C_BEQ:   x.pcs = zero ? 2'd1 : 2'd0;
        C_BNE:   x.pcs = zero ? 2'd0 : 2'd1;
        C_J:     x.pcs = 2'd2;
        default: x.pcs = 2'd0;
      endcase
      x.done = (e.cls == C_BEQ || e.cls == C_BNE || e.cls == C_J);
      q.push_back(x);
      is_mem = (e.cls == C_LD || e.cls == C_ST);
      if (is_mem) begin
        nm = (ack_at >= 1 && ack_at <= MEM_WAIT_MAX) ? ack_at : MEM_WAIT_MAX;
        for (int i = 1; i <= nm; i++) begin
          m = '0; m.alu = x.alu; m.s1 = x.s1; m.s2 = x.s2;
          m.mreq = 1'b1; m.mwe = (e.cls == C_ST);
          if (i == nm) begin
            if (ack_at == nm) m.done = (e.cls == C_ST);
            else begin m.merr = 1'b1; m.done = 1'b1; end
          end
          q.push_back(m);
        end
      end
      if (e.cls == C_ALU || (e.cls == C_LD && ack_at == nm)) begin
        wb = '0; wb.rfw = 1'b1; wb.done = 1'b1; wb.ws = (e.cls == C_LD);
        wb.wa = e.use_fn ? w[15:11] : w[20:16];
        q.push_back(wb);
      end
    end
    step(1'b1, w, 1'($urandom), 1'($urandom), idle(), $sformatf("hs_%h", w));
    for (int k = 1; k <= q.size(); k++) begin
      if (k == rst_at) begin
        inst_valid = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rst_async", sample(), idle());
        @(posedge clk);
        #1 chk("rst_hold", sample(), idle());
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        break;
      end
      mi = k - 2;
      in_mem = is_mem && mi >= 1 && mi <= nm;
      ack = in_mem ? (mi == ack_at) : 1'($urandom);
      step(1'($urandom), $urandom, ack, (k == 2) ? zero : 1'($urandom), q[k-1],
           $sformatf("%h_c%0d", w, k));
    end
  endtask

  function automatic logic [31:0] rand_legal();
    ent_t e;
    logic [31:0] w;
    e = tbl[$urandom_range(0, tbl.size() - 1)];
    w = $urandom;
    w[31:26] = e.op;
    if (e.use_fn) w[5:0] = e.fn;
    return w;
  endfunction

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst = '0; mem_ack = 1'b0; alu_zero = 1'b0;
    init_table();
    #1 chk("reset", sample(), idle());
    @(negedge clk);
    chk("reset_neg", sample(), idle());
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_inst(32'h00221821, 0, 1'b0, 0);
    run_inst(32'h00031103, 0, 1'b0, 0);
    run_inst(32'h8C220004, 3, 1'b0, 0);
    run_inst(32'hAC220004, 0, 1'b0, 0);
    run_inst(32'hAC220004, MEM_WAIT_MAX, 1'b0, 0);
    run_inst(32'h8C220004, MEM_WAIT_MAX, 1'b0, 0);
    run_inst(32'h10220003, 0, 1'b1, 0);
    run_inst(32'h14220003, 0, 1'b1, 0);
    run_inst(32'h10220003, 0, 1'b0, 0);
    run_inst(32'h08000010, 0, 1'b0, 0);
    run_inst(32'hFC000000, 0, 1'b0, 0);
    run_inst(32'h8C220004, 0, 1'b0, 4);
    run_inst(32'h00221821, 0, 1'b0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] w;
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, $urandom, 1'($urandom), 1'($urandom), idle(), "gap");
      end
      w = ($urandom_range(0, 9) == 0) ? $urandom : rand_legal();
      run_inst(w, $urandom_range(0, MEM_WAIT_MAX + 2), 1'($urandom),
               ($urandom_range(0, 40) == 0) ? $urandom_range(1, 5) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
